alarm_rom_arbiter: RTL and testbench
====================================

ALARM_ROM_ARBITER -- requirements
Module: alarm_rom_arbiter

Interface
REQ-001 Parameter DEPTH, default 20480, number of valid 32-bit words in the shared on-chip memory.
REQ-002 Parameter ADDR_W, default 15, word-address width.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 m0_address  in  ADDR_W  requester 0 (CPU data master) word address.
REQ-006 m0_read / m0_write  in  1 each  requester 0 read / write request; never both high.
REQ-007 m0_byteenable  in  4  requester 0 write byte lanes.
REQ-008 m0_writedata  in  32  requester 0 write data.
REQ-009 m0_waitrequest  out  1  high = requester 0 command not accepted.
REQ-010 m0_readdata  out  32  requester 0 read data; m0_readdatavalid  out  1  qualifies it.
REQ-011 m1_address  in  ADDR_W; m1_read  in  1  requester 1 (tone player) read-only port.
REQ-012 m1_waitrequest, m1_readdatavalid  out  1 each; m1_readdata  out  32.
REQ-013 mem_address  out  ADDR_W; mem_chipselect, mem_write, mem_debugaccess  out  1 each.
REQ-014 mem_byteenable  out  4; mem_writedata  out  32; mem_readdata  in  32  memory q (valid one cycle after address is sampled).
REQ-015 err_sticky  out  1  out-of-range access seen; err_clear  in  1  clears it.

Function
REQ-016 FSM states IDLE, ISSUE, DATA; one memory transaction in flight at a time.
REQ-017 IDLE: if any request is pending, latch winner id, address, byteenable, writedata, and read/write kind into hold registers, then go to ISSUE; otherwise stay.
REQ-018 Arbitration: single requester wins outright; both pending -> grant the one not granted last (round-robin pointer updated on each grant).
REQ-019 ISSUE: drive mem_* from hold registers; mem_chipselect=1 unless out of range; mem_write=mem_debugaccess=1 only for an in-range m0 write; winner's waitrequest=0 for exactly this cycle.
REQ-020 ISSUE exit: write -> IDLE; read -> DATA.
REQ-021 DATA: winner's readdatavalid=1 for exactly one cycle; readdata=mem_readdata (0x00000000 if out of range); next state IDLE.
REQ-022 Latencies: write accepted 2 cycles after request first seen in IDLE; read data 3 cycles after request first seen in IDLE.
REQ-023 Both waitrequests are 1 in every cycle other than the winner's ISSUE cycle; readdata outputs are 0 when readdatavalid=0.
REQ-024 Out of range is address >= DEPTH: no chipselect, write dropped, err_sticky set at end of ISSUE.
REQ-025 err_clear and a new error in the same cycle: set wins.
REQ-026 Requests arriving during ISSUE/DATA are held by waitrequest and arbitrated on the next IDLE.
REQ-027 mem_* outputs are 0 outside ISSUE.

Reset
REQ-028 On reset: state IDLE, round-robin pointer = m1 (so m0 wins the first tie), err_sticky=0, hold registers 0, waitrequests=1, readdatavalids=0, all mem_* outputs 0.
REQ-029 Reset during ISSUE or DATA aborts the transaction: no readdatavalid pulse, no memory write after reset is sampled.

Verification
REQ-030 m0 writes 0xCAFEF00D, byteenable 0xF, addr 0x0010; then m0 reads 0x0010 -> one write cycle with mem_write=1; m0_readdatavalid with 0xCAFEF00D 3 cycles after the read request.
REQ-031 m0 and m1 read simultaneously from the reset state -> m0 served first; m1 waitrequest drops 3 cycles later; the next tie goes to m1.
REQ-032 m1 continuous reads with m0 continuous reads -> strict alternation; neither starves over 100 transactions.
REQ-033 m0 write to addr 20480 -> mem_chipselect stays 0, err_sticky=1; m1 read at 0x5000 returns 0x00000000; err_clear -> err_sticky=0.
REQ-034 Reset asserted in DATA of an m1 read -> no m1_readdatavalid; all outputs at reset values the next cycle.
REQ-035 Random m0/m1 traffic against a memory model -> readdata matches the model; at most one mem_chipselect per 2 cycles.

Source files
------------

// File: rtl/alarm_rom_arbiter.sv
// Two-requester arbiter in front of a single-port on-chip memory: m0 (CPU, read/write)
// and m1 (tone player, read-only) are served one transaction at a time, round-robin on ties.
module alarm_rom_arbiter #(
    parameter int unsigned DEPTH  = 20480,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [3:0]        m0_byteenable,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic              mem_debugaccess,
    output logic [3:0]        mem_byteenable,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,
    output logic              err_sticky,
    input  logic              err_clear
);

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    localparam logic [32:0] DEPTH_EXT = 33'(DEPTH);

    state_t              state_q, state_d;
    logic                winner_q, winner_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          be_q, be_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                isWrite_q, isWrite_d;
    logic                rrLast_q, rrLast_d;
    logic                err_q, err_d;
    logic                pend0, pend1, winSel, inRange;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            winner_q  <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            isWrite_q <= 1'b0;
            rrLast_q  <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            isWrite_q <= isWrite_d;
            rrLast_q  <= rrLast_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        winner_d         = winner_q;
        addr_d           = addr_q;
        be_d             = be_q;
        wdata_d          = wdata_q;
        isWrite_d        = isWrite_q;
        rrLast_d         = rrLast_q;
        err_d            = err_q;
        pend0            = m0_read | m0_write;
        pend1            = m1_read;
        winSel           = 1'b0;
        inRange          = (33'(addr_q) < DEPTH_EXT);
        m0_waitrequest   = 1'b1;
        m1_waitrequest   = 1'b1;
        m0_readdata      = '0;
        m1_readdata      = '0;
        m0_readdatavalid = 1'b0;
        m1_readdatavalid = 1'b0;
        mem_address      = '0;
        mem_chipselect   = 1'b0;
        mem_write        = 1'b0;
        mem_debugaccess  = 1'b0;
        mem_byteenable   = '0;
        mem_writedata    = '0;

        // A fresh error in ISSUE overrides a simultaneous clear.
        if (err_clear) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (pend0 || pend1) begin
                    winSel    = (pend0 && pend1) ? ~rrLast_q : pend1;
                    winner_d  = winSel;
                    rrLast_d  = winSel;
                    addr_d    = winSel ? m1_address : m0_address;
                    be_d      = winSel ? 4'h0 : m0_byteenable;
                    wdata_d   = winSel ? 32'h0 : m0_writedata;
                    isWrite_d = ~winSel & m0_write;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                mem_address     = addr_q;
                mem_chipselect  = inRange;
                mem_write       = inRange & isWrite_q & ~winner_q;
                mem_debugaccess = inRange & isWrite_q & ~winner_q;
                mem_byteenable  = be_q;
                mem_writedata   = wdata_q;
                m0_waitrequest  = winner_q;
                m1_waitrequest  = ~winner_q;
                if (!inRange) begin
                    err_d = 1'b1;
                end
                state_d = isWrite_q ? IDLE : DATA;
            end
            DATA: begin
                m0_readdatavalid = ~winner_q;
                m1_readdatavalid = winner_q;
                m0_readdata      = (!winner_q && inRange) ? mem_readdata : 32'h0;
                m1_readdata      = (winner_q && inRange) ? mem_readdata : 32'h0;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Reset aborts the cycle in flight: no data pulse and no memory write escape.
        if (reset) begin
            m0_waitrequest   = 1'b1;
            m1_waitrequest   = 1'b1;
            m0_readdata      = '0;
            m1_readdata      = '0;
            m0_readdatavalid = 1'b0;
            m1_readdatavalid = 1'b0;
            mem_address      = '0;
            mem_chipselect   = 1'b0;
            mem_write        = 1'b0;
            mem_debugaccess  = 1'b0;
            mem_byteenable   = '0;
            mem_writedata    = '0;
        end
    end

    assign err_sticky = err_q;

endmodule

// File: tb/tb_alarm_rom_arbiter.sv
// Scoreboard bench for alarm_rom_arbiter: expected read data is queued per requester when
// the command is accepted and compared when readdatavalid fires.
module tb_alarm_rom_arbiter;

    localparam int DEPTH  = 20480;
    localparam int ADDR_W = 15;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] m0_address;
    logic              m0_read, m0_write;
    logic [3:0]        m0_byteenable;
    logic [31:0]       m0_writedata;
    logic              m0_waitrequest, m0_readdatavalid;
    logic [31:0]       m0_readdata;
    logic [ADDR_W-1:0] m1_address;
    logic              m1_read;
    logic              m1_waitrequest, m1_readdatavalid;
    logic [31:0]       m1_readdata;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_chipselect, mem_write, mem_debugaccess;
    logic [3:0]        mem_byteenable;
    logic [31:0]       mem_writedata, mem_readdata;
    logic              err_sticky, err_clear;

    logic [31:0] ram    [0:32767];
    logic [31:0] refMem [0:32767];
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    int          grantLog[$];

    int checks = 0;
    int errors = 0;
    int cycleCount = 0;
    int csCount = 0;
    int memWriteCount = 0;
    int lastCs = -10;
    int lastValid0 = 0;
    int valid1Count = 0;
    int acc0, acc0b, acc1, rc, tmp, viol;

    alarm_rom_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_debugaccess(mem_debugaccess), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .err_sticky(err_sticky), .err_clear(err_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycleCount <= cycleCount + 1;

    // Behavioural single-port memory with registered q.
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    function automatic logic [31:0] expRead(input logic [ADDR_W-1:0] addr);
        if (int'(addr) >= DEPTH) return 32'h0;
        return refMem[addr];
    endfunction

    task automatic modelWrite(input logic [ADDR_W-1:0] addr, input logic [31:0] data, input logic [3:0] be);
        if (int'(addr) < DEPTH)
            for (int b = 0; b < 4; b++)
                if (be[b]) refMem[addr][8*b +: 8] = data[8*b +: 8];
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (m0_readdatavalid) begin
                lastValid0 = cycleCount;
                if (q0.size() == 0) checkOutput("m0 unexpected valid", 32'd1, 32'd0);
                else checkOutput("m0 rdata", m0_readdata, q0.pop_front());
            end else begin
                checkOutput("m0 rdata idle", m0_readdata, 32'h0);
            end
            if (m1_readdatavalid) begin
                valid1Count++;
                if (q1.size() == 0) checkOutput("m1 unexpected valid", 32'd1, 32'd0);
                else checkOutput("m1 rdata", m1_readdata, q1.pop_front());
            end else begin
                checkOutput("m1 rdata idle", m1_readdata, 32'h0);
            end
            checkOutput("single grant", {31'h0, m0_waitrequest | m1_waitrequest}, 32'd1);
            if (mem_chipselect) begin
                checkOutput("cs spacing", {31'h0, (cycleCount - lastCs) >= 2}, 32'd1);
                lastCs = cycleCount;
                csCount++;
            end
            if (mem_write) memWriteCount++;
        end
    end

    // Drives one m0 command from a posedge+1 slot and returns one cycle after acceptance.
    task automatic m0Xfer(input logic isWrite, input logic [ADDR_W-1:0] addr, input logic [31:0] data,
                          input logic [3:0] be, output int acceptCycle);
        m0_address = addr; m0_write = isWrite; m0_read = ~isWrite;
        m0_byteenable = be; m0_writedata = data;
        acceptCycle = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!m0_waitrequest) begin
                acceptCycle = cycleCount;
                break;
            end
        end
        if (acceptCycle < 0) begin
            checkOutput("m0 accept timeout", 32'd0, 32'd1);
        end else begin
            grantLog.push_back(0);
            if (isWrite) modelWrite(addr, data, be);
            else q0.push_back(expRead(addr));
        end
        @(posedge clk); #1;
        m0_read = 1'b0; m0_write = 1'b0;
    endtask

    task automatic m1Read(input logic [ADDR_W-1:0] addr, output int acceptCycle);
        m1_address = addr; m1_read = 1'b1;
        acceptCycle = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!m1_waitrequest) begin
                acceptCycle = cycleCount;
                break;
            end
        end
        if (acceptCycle < 0) begin
            checkOutput("m1 accept timeout", 32'd0, 32'd1);
        end else begin
            grantLog.push_back(1);
            q1.push_back(expRead(addr));
        end
        @(posedge clk); #1;
        m1_read = 1'b0;
    endtask

    task automatic applyStimulus_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        q0.delete(); q1.delete();
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, " m0 wait"}, {31'h0, m0_waitrequest}, 32'd1);
        checkOutput({tag, " m1 wait"}, {31'h0, m1_waitrequest}, 32'd1);
        checkOutput({tag, " valids"}, {30'h0, m0_readdatavalid, m1_readdatavalid}, 32'd0);
        checkOutput({tag, " rdata"}, m0_readdata | m1_readdata, 32'h0);
        checkOutput({tag, " mem ctl"}, {29'h0, mem_chipselect, mem_write, mem_debugaccess}, 32'd0);
        checkOutput({tag, " mem addr"}, {17'h0, mem_address}, 32'h0);
        checkOutput({tag, " err"}, {31'h0, err_sticky}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) begin
            ram[i] = 32'h0;
            refMem[i] = 32'h0;
        end
        reset = 1'b1; err_clear = 1'b0;
        m0_address = '0; m0_read = 1'b0; m0_write = 1'b0; m0_byteenable = '0; m0_writedata = '0;
        m1_address = '0; m1_read = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("in reset");
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checkResetOutputs("after reset");
        @(posedge clk); #1;

        // Write then read back with latency checks.
        rc = cycleCount; tmp = memWriteCount;
        m0Xfer(1'b1, 15'h0010, 32'hCAFEF00D, 4'hF, acc0);
        checkOutput("write latency", 32'(acc0 - rc + 1), 32'd2);
        checkOutput("one mem write", 32'(memWriteCount - tmp), 32'd1);
        rc = cycleCount;
        m0Xfer(1'b0, 15'h0010, 32'h0, 4'h0, acc0);
        repeat (3) @(posedge clk); #1;
        checkOutput("read latency", 32'(lastValid0 - rc + 1), 32'd3);
        checkOutput("m0 q drained", 32'(q0.size()), 32'd0);
        m0Xfer(1'b1, 15'h0010, 32'h00AB0000, 4'h4, acc0);
        m0Xfer(1'b0, 15'h0010, 32'h0, 4'h0, acc0);
        repeat (3) @(posedge clk); #1;

        // Tie from reset: m0 first; then m0 re-requests and loses the tie to m1.
        applyStimulus_reset();
        fork
            m0Xfer(1'b0, 15'h0010, 32'h0, 4'h0, acc0);
            m1Read(15'h0010, acc1);
        join
        checkOutput("tie m1 after m0", 32'(acc1 - acc0), 32'd3);
        fork
            begin
                m0Xfer(1'b0, 15'h0011, 32'h0, 4'h0, acc0);
                m0Xfer(1'b0, 15'h0010, 32'h0, 4'h0, acc0b);
            end
            m1Read(15'h0012, acc1);
        join
        checkOutput("second tie to m1", {31'h0, (acc0 < acc1) && (acc1 < acc0b)}, 32'd1);
        repeat (3) @(posedge clk); #1;

        // Continuous contention must alternate strictly.
        grantLog.delete();
        fork
            repeat (50) m0Xfer(1'b0, 15'($urandom_range(0, 31)), 32'h0, 4'h0, tmp);
            repeat (50) m1Read(15'($urandom_range(0, 31)), acc1);
        join
        viol = 0;
        for (int i = 1; i < grantLog.size(); i++)
            if (grantLog[i] == grantLog[i-1]) viol++;
        checkOutput("alternation", 32'(viol), 32'd0);
        checkOutput("grant count", 32'(grantLog.size()), 32'd100);
        repeat (3) @(posedge clk); #1;

        // Out-of-range access, sticky error, clear, and set-wins-over-clear.
        tmp = csCount;
        m0Xfer(1'b1, 15'(DEPTH), 32'hDEADBEEF, 4'hF, acc0);
        checkOutput("oor no cs", 32'(csCount - tmp), 32'd0);
        checkOutput("err set", {31'h0, err_sticky}, 32'd1);
        m1Read(15'h5000, acc1);
        repeat (2) @(posedge clk); #1;
        err_clear = 1'b1;
        @(posedge clk); #1 err_clear = 1'b0;
        @(negedge clk);
        checkOutput("err cleared", {31'h0, err_sticky}, 32'd0);
        @(posedge clk); #1 err_clear = 1'b1;
        m0Xfer(1'b1, 15'h7FFF, 32'h12345678, 4'hF, acc0);
        @(negedge clk);
        checkOutput("err set wins", {31'h0, err_sticky}, 32'd1);
        @(posedge clk); #1 err_clear = 1'b0;

        // Reset during DATA of an m1 read suppresses its data pulse.
        m1Read(15'h0010, acc1);
        reset = 1'b1;
        q1.delete();
        tmp = valid1Count;
        @(negedge clk);
        checkOutput("no valid in reset", {31'h0, m1_readdatavalid}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checkResetOutputs("data abort");
        repeat (3) @(posedge clk); #1;
        checkOutput("no late valid", 32'(valid1Count - tmp), 32'd0);

        // Random mixed traffic against the reference memory.
        fork
            repeat (40) begin
                m0Xfer(1'($urandom_range(0, 1)),
                       ($urandom_range(0, 9) == 0) ? 15'(DEPTH + $urandom_range(0, 7)) : 15'($urandom_range(0, 63)),
                       $urandom, 4'($urandom_range(1, 15)), tmp);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            repeat (40) begin
                m1Read(15'($urandom_range(0, 63)), acc1);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
        join
        repeat (4) @(posedge clk); #1;
        checkOutput("q0 drained", 32'(q0.size()), 32'd0);
        checkOutput("q1 drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
